// File: rtl/e_muldiv_unit.sv
// rtl/e_muldiv_unit.sv - E-stage multi-cycle multiply/divide unit with HI/LO registers
// Result is computed at issue; Busy models the latency before HI/LO commit.
module e_muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] temp_hi_q, temp_hi_d;
  logic [WIDTH-1:0] temp_lo_q, temp_lo_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               sdiv, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b, divisor, uq, ur, quo, rem;

  // Low 2*WIDTH bits of a product are sign-agnostic, so sign-extend and multiply.
  always_comb begin
    prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  end

  // Shared magnitude divider; most-negative / -1 falls out as the wrapped value with rem 0.
  always_comb begin
    sdiv    = (MDOp == 3'd3);
    a_neg   = sdiv & A[WIDTH-1];
    b_neg   = sdiv & B[WIDTH-1];
    b_zero  = (B == '0);
    abs_a   = a_neg ? (~A + 1'b1) : A;
    abs_b   = b_neg ? (~B + 1'b1) : B;
    divisor = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
    uq      = abs_a / divisor;
    ur      = abs_a % divisor;
    quo     = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
    rem     = a_neg ? (~ur + 1'b1) : ur;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    wr_d      = wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (MDOp)
            3'd1, 3'd2: begin
              temp_hi_d = (MDOp == 3'd1) ? prod_s[2*WIDTH-1:WIDTH] : prod_u[2*WIDTH-1:WIDTH];
              temp_lo_d = (MDOp == 3'd1) ? prod_s[WIDTH-1:0] : prod_u[WIDTH-1:0];
              cnt_d     = MULT_N;
              busy_d    = 1'b1;
              wr_d      = 1'b1;
              state_d   = BUSY;
            end
            3'd3, 3'd4: begin
              temp_hi_d = rem;
              temp_lo_d = quo;
              cnt_d     = DIV_N;
              busy_d    = 1'b1;
              wr_d      = ~b_zero;
              state_d   = BUSY;
            end
            3'd5:    hi_d = A;
            3'd6:    lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (wr_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wr_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      wr_q      <= wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// tb/tb_e_muldiv_unit.sv - directed self-checking bench for e_muldiv_unit
module tb_e_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  e_muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op in cycle t, check Busy and held HI/LO for n cycles, then the commit.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    Start = 1'b1; MDOp = op; A = a; B = b;
    step();
    Start = 1'b0; MDOp = 3'd0;
    for (int i = 1; i <= n; i++) begin
      chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
      chk({tag, "_hold_hi"}, HI, old_hi);
      chk({tag, "_hold_lo"}, LO, old_lo);
      step();
    end
    chk({tag, "_done_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_hi"}, HI, new_hi);
    chk({tag, "_lo"}, LO, new_lo);
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1; MDOp = op; A = a; B = 32'd0;
    step();
    Start = 1'b0; MDOp = 3'd0;
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = '0; B = '0;
    step();
    step();
    reset = 1'b0;
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);

    // mult in flight, reset applied for 2 cycles while counter is 3
    Start = 1'b1; MDOp = 3'd1; A = 32'hFFFF_FFFE; B = 32'd3;
    step();
    Start = 1'b0; MDOp = 3'd0;
    step();
    step();
    chk("abort_busy_before", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    for (int i = 0; i < 8; i++) step();
    chk("abort_late_busy", {31'd0, Busy}, 32'd0);
    chk("abort_late_hi", HI, 32'd0);
    chk("abort_late_lo", LO, 32'd0);

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5,
           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10,
           32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);
    run_op("divu", 3'd4, 32'd100, 32'd7, 10,
           32'h0000_0000, 32'h8000_0000, 32'h0000_0002, 32'h0000_000E);
    run_op("div_negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10,
           32'h0000_0002, 32'h0000_000E, 32'h0000_0001, 32'hFFFF_FFFD);

    // mthi then mtlo on consecutive cycles
    Start = 1'b1; MDOp = 3'd5; A = 32'h1234;
    step();
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_lo", LO, 32'hFFFF_FFFD);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    MDOp = 3'd6; A = 32'h5678;
    step();
    Start = 1'b0; MDOp = 3'd0;
    chk("mtlo_hi", HI, 32'h1234);
    chk("mtlo_lo", LO, 32'h5678);
    chk("mtlo_busy", {31'd0, Busy}, 32'd0);

    // MDOp 0 and 7 are no-ops
    Start = 1'b1; MDOp = 3'd0; A = 32'hDEAD; B = 32'hBEEF;
    step();
    MDOp = 3'd7;
    step();
    Start = 1'b0; MDOp = 3'd0;
    step();
    chk("noop_busy", {31'd0, Busy}, 32'd0);
    chk("noop_hi", HI, 32'h1234);
    chk("noop_lo", LO, 32'h5678);

    move(3'd5, 32'h11);
    move(3'd6, 32'h22);
    run_op("divu_zero", 3'd4, 32'd1234, 32'd0, 10,
           32'h11, 32'h22, 32'h11, 32'h22);

    // mult with an mtlo attempted during Busy
    Start = 1'b1; MDOp = 3'd1; A = 32'd3; B = 32'd5;
    step();
    Start = 1'b0; MDOp = 3'd0;
    for (int i = 1; i <= 5; i++) begin
      chk("ign_busy", {31'd0, Busy}, 32'd1);
      chk("ign_hold_lo", LO, 32'h22);
      if (i == 2) begin
        Start = 1'b1; MDOp = 3'd6; A = 32'hAAAA;
      end else begin
        Start = 1'b0; MDOp = 3'd0;
      end
      step();
    end
    chk("ign_done_busy", {31'd0, Busy}, 32'd0);
    chk("ign_hi", HI, 32'h0);
    chk("ign_lo", LO, 32'hF);
    step();
    chk("ign_after_lo", LO, 32'hF);
    chk("ign_after_busy", {31'd0, Busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_muldiv_unit.md
Name: e_muldiv_unit

Overview:
- E-stage multiply/divide unit for the pipelined MIPS core; successor to the single-cycle E-stage ALU/control path.
- Adds multi-cycle latency, a Busy handshake and the HI/LO architectural registers, with operand width and per-operation latency parametrised.
- The hazard unit stalls D-stage on (Start | Busy) when the D instruction is a mult/div/mfhi/mflo/mthi/mtlo.
- mfhi/mflo read HI/LO combinationally in E.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, cycles Busy is held for mult/multu (>=1)
DIV_CYCLES, 10, cycles Busy is held for div/divu (>=1)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous active-high reset
Start  input  1  op request valid this cycle, from E_Controller decode
MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
A  input  WIDTH  rs operand (forwarded)
B  input  WIDTH  rt operand (forwarded)
Busy  output  1  multi-cycle op in progress
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset, checked first each edge, overrides everything: HI=0, LO=0, Busy=0, counter=0, state IDLE. Reset mid-operation aborts the op; its result is never written.
- States are IDLE and BUSY, with a counter of width clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- IDLE with Start=1 and MDOp in 1..4: A and B are latched, the result is computed into internal tempHI/tempLO, counter loads N (MULT_CYCLES or DIV_CYCLES), and the state goes to BUSY.
- Busy is registered: it is 1 for exactly N cycles, the cycles t+1..t+N after Start in cycle t.
- BUSY: counter decrements each cycle. On the edge where counter==1, HI<=tempHI, LO<=tempLO, Busy<=0 and the state returns to IDLE. New HI/LO and Busy=0 are visible together in cycle t+N+1.
- IDLE with Start=1 and MDOp=5: HI<=A at the next edge. Busy stays 0 and LO is unchanged.
- IDLE with Start=1 and MDOp=6: LO<=A at the next edge. Busy stays 0 and HI is unchanged.
- Start=1 with MDOp 0 or 7 is a no-op.
- Start while Busy=1 is ignored entirely: no latch, no restart, and HI/LO are not written. The stall logic guarantees this never happens legally.
- HI and LO hold their current (old) values throughout BUSY.
- mult: signed 2*WIDTH product; HI=upper WIDTH bits, LO=lower WIDTH bits.
- multu: the same, unsigned.
- div: signed division. LO=quotient truncated toward zero; HI=remainder, carrying the sign of the dividend.
- divu: unsigned division; LO=quotient, HI=remainder.
- Signed overflow (A=most-negative, B=-1): LO=most-negative value, HI=0.
- Divide by zero (div or divu with B=0): the op still runs DIV_CYCLES with Busy=1, and HI and LO are left unchanged at completion.
- The unit does not modify or depend on the E-stage T_new encoding. Its registers are not forwarded; consumers read HI/LO only via mfhi/mflo after Busy=0.

Test Plan:
- Reset held 2 cycles during a mult in flight at count 3 -> Busy=0, HI=0, LO=0 the cycle after reset; no later write.
- mult, A=0xFFFFFFFE (-2), B=0x00000003, Start at t -> Busy=1 for t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- multu with the same operands -> at t+6 HI=0x00000002, LO=0xFFFFFFFA.
- div, A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu with B=0 and prior HI=0x11, LO=0x22 -> Busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
- mthi A=0x1234 then mtlo A=0x5678 on consecutive cycles -> HI=0x1234 after the first edge, LO=0x5678 after the second; Busy never rises.
- mult started, then Start with MDOp=6 (A=0xAAAA) during Busy -> ignored; LO equals the product at completion, not 0xAAAA.
